md_unit: RTL and testbench
==========================

# md_unit

Execute-stage multiply/divide unit for the pipelined MIPS core. It sits directly downstream of the D/E pipeline register and consumes that register's `E_rsValue_o`, `E_rtValue_o` and a dedicated md-op field. It owns the architectural HI/LO registers and runs multi-cycle multiply and divide operations. It reports `busy_o`/`start_o` back to the hazard unit, which converts them into the `stall` input of the D/E register.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy duration of MULT/MULTU
- `DIV_CYCLES`, 10, busy duration of DIV/DIVU

Ports:
- `clk`  in  1  single clock, all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `E_rsValue_i`  in  32  operand A (rs)
- `E_rtValue_i`  in  32  operand B (rt)
- `E_MDop_i`  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; other codes are treated as NONE
- `start_o`  out  1  combinational; high when `E_MDop_i` is 1..4 and `busy_o`=0
- `busy_o`  out  1  registered; high while an operation is in flight
- `HI_o`  out  32  architectural HI register
- `LO_o`  out  32  architectural LO register
- `MD_out_o`  out  32  combinational: HI_o for MFHI, LO_o for MFLO, 0 otherwise

## Operation
- State is IDLE/RUN, encoded by `busy_o`, plus a down-counter `cnt`, latched pending results `hi_n`/`lo_n` and an op flag.
- IDLE, start op sampled at an edge:
  - compute the full result from the sampled operands and latch it into `hi_n`/`lo_n`;
  - load `cnt` with MULT_CYCLES or DIV_CYCLES;
  - set `busy_o`=1.
- RUN: `cnt` decrements each edge. At the edge where `cnt` goes 1→0, HI/LO take `hi_n`/`lo_n` and `busy_o` drops.
- MULT: {HI,LO} = signed 32×32 → 64-bit product. MULTU: the unsigned product.
- DIV: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divisor 0 (DIV/DIVU): busy timing is identical to a normal divide; HI/LO keep their previous values at commit.
- MTHI/MTLO in IDLE: HI (resp. LO) takes `E_rsValue_i` at the edge. The other register is unchanged.
- Any op sampled while `busy_o`=1 is ignored. This covers start ops, MTHI and MTLO. The hazard unit guarantees none arrive; the ignore is defensive.
- MFHI/MFLO never stall inside this block. They read current HI/LO; in-flight results are not forwarded.
- Reset at any point, including mid-RUN: HI=0, LO=0, `busy_o`=0, `cnt`=0, pending result discarded.

## Timing
- Reset values: `HI_o`=0, `LO_o`=0, `busy_o`=0. `start_o` and `MD_out_o` follow their combinational definitions.
- Start sampled at edge T0 → `busy_o` is high during cycles T0+1 … T0+N, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO are updated at edge T0+N, in the same edge where `busy_o` falls.
- A new start is accepted at edge T0+N+1 at the earliest. It is not accepted at T0+N itself, because `busy_o` is still 1 in the cycle before that edge.
- MTHI/MTLO latency is one edge. MFHI/MFLO latency is zero (combinational).
- Hazard contract: stall D while an md op sits in D and (`busy_o` | `start_o`).

## Structure
- Shared package/header:
  - MDop encodings `MD_NONE` … `MD_MTLO`;
  - default cycle counts.
- The decoder uses the same constants.
- One sub-module is natural: `md_divider`, a combinational signed/unsigned div/rem with the divide-by-zero flag and the INT_MIN/−1 case.
- Multiply stays inline.
- `cnt` width is 4 bits; it must hold max(MULT_CYCLES, DIV_CYCLES).

## Test plan
- MULT: rs=0xFFFFFFFE, rt=3 → `busy_o` high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MFHI returns 0xFFFFFFFF afterward.
- MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV: rs=−7 (0xFFFFFFF9), rt=2 → `busy_o` high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. In a separate DIV: rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU by zero: preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIVU rs=5, rt=0 → 10 busy cycles, HI/LO remain 0x11/0x22.
- During busy: present MULT and MTLO with new values → both ignored, counter not restarted. The original result commits on schedule, and `start_o` stays 0 throughout.
- Reset asserted in cycle 4 of a DIV → next cycle `busy_o`=0, HI=LO=0. No later commit occurs.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared constants for the execute-stage multiply/divide unit:
// md-op encodings and default operation latencies.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int CNT_W           = 4;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_md_divider.sv
// Combinational signed/unsigned 32-bit divide with remainder, flagging
// divide-by-zero and pinning the INT_MIN / -1 overflow case.
module md_divider (
  input  logic        is_signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o,
  output logic        div_zero_o
);
  logic        a_neg_s, b_neg_s, ovf_s;
  logic [31:0] a_mag_s, b_mag_s, b_safe_s, q_mag_s, r_mag_s;

  assign a_neg_s    = is_signed_i & a_i[31];
  assign b_neg_s    = is_signed_i & b_i[31];
  assign a_mag_s    = a_neg_s ? (32'd0 - a_i) : a_i;
  assign b_mag_s    = b_neg_s ? (32'd0 - b_i) : b_i;
  assign div_zero_o = (b_i == 32'd0);
  // A dummy divisor of one keeps the datapath defined; the caller discards the result.
  assign b_safe_s   = div_zero_o ? 32'd1 : b_mag_s;
  assign q_mag_s    = a_mag_s / b_safe_s;
  assign r_mag_s    = a_mag_s % b_safe_s;
  assign ovf_s      = is_signed_i && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

  always_comb begin
    quo_o = 32'd0;
    rem_o = 32'd0;
    if (ovf_s) begin
      quo_o = 32'h8000_0000;
      rem_o = 32'd0;
    end else begin
      quo_o = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
      rem_o = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
    end
  end
endmodule

// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO. Results are computed
// at start, held pending, and committed when the busy counter expires.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_rsValue_i,
  input  logic [31:0] E_rtValue_i,
  input  logic [3:0]  E_MDop_i,
  output logic        start_o,
  output logic        busy_o,
  output logic [31:0] HI_o,
  output logic [31:0] LO_o,
  output logic [31:0] MD_out_o
);
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_n_q, hi_n_d, lo_n_q, lo_n_d;
  logic             commit_q, commit_d;

  logic             mul_signed_s, div_signed_s, div_zero_s;
  logic [63:0]      mul_a_s, mul_b_s, prod_s;
  logic [31:0]      quo_s, rem_s;

  // Sign- or zero-extending to 64 bits lets one unsigned multiplier serve both forms.
  assign mul_signed_s = (E_MDop_i == MD_MULT);
  assign mul_a_s      = {{32{mul_signed_s & E_rsValue_i[31]}}, E_rsValue_i};
  assign mul_b_s      = {{32{mul_signed_s & E_rtValue_i[31]}}, E_rtValue_i};
  assign prod_s       = mul_a_s * mul_b_s;
  assign div_signed_s = (E_MDop_i == MD_DIV);

  md_divider u_div (
    .is_signed_i (div_signed_s),
    .a_i         (E_rsValue_i),
    .b_i         (E_rtValue_i),
    .quo_o       (quo_s),
    .rem_o       (rem_s),
    .div_zero_o  (div_zero_s)
  );

  assign start_o = !busy_q && is_start_op(E_MDop_i);
  assign busy_o  = busy_q;
  assign HI_o    = hi_q;
  assign LO_o    = lo_q;

  always_comb begin
    case (E_MDop_i)
      MD_MFHI: MD_out_o = hi_q;
      MD_MFLO: MD_out_o = lo_q;
      default: MD_out_o = 32'd0;
    endcase
  end

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_n_d   = hi_n_q;
    lo_n_d   = lo_n_q;
    commit_d = commit_q;
    if (busy_q) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        if (commit_q) begin
          hi_d = hi_n_q;
          lo_d = lo_n_q;
        end else begin
          hi_d = hi_q;
        end
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      case (E_MDop_i)
        MD_MULT, MD_MULTU: begin
          hi_n_d   = prod_s[63:32];
          lo_n_d   = prod_s[31:0];
          commit_d = 1'b1;
          cnt_d    = 4'(MULT_CYCLES);
          busy_d   = 1'b1;
        end
        MD_DIV, MD_DIVU: begin
          hi_n_d   = rem_s;
          lo_n_d   = quo_s;
          commit_d = !div_zero_s;
          cnt_d    = 4'(DIV_CYCLES);
          busy_d   = 1'b1;
        end
        MD_MTHI: hi_d = E_rsValue_i;
        MD_MTLO: lo_d = E_rsValue_i;
        default: busy_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_n_q   <= 32'd0;
      lo_n_q   <= 32'd0;
      commit_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_n_q   <= hi_n_d;
      lo_n_q   <= lo_n_d;
      commit_q <= commit_d;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// Directed, table-driven bench for md_unit: arithmetic vectors, HI/LO moves,
// divide-by-zero, busy-time op rejection and mid-operation reset.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rs, rt;
  logic [3:0]  op;
  logic        start_o, busy_o;
  logic [31:0] hi_o, lo_o, md_out_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .E_rsValue_i (rs),
    .E_rtValue_i (rt),
    .E_MDop_i    (op),
    .start_o     (start_o),
    .busy_o      (busy_o),
    .HI_o        (hi_o),
    .LO_o        (lo_o),
    .MD_out_o    (md_out_o)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_start;
    int          exp_cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold op for one edge, then count busy cycles until it falls (bounded).
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    op = o; rs = a; rt = b;
    step();
    op = MD_NONE; rs = 32'd0; rt = 32'd0;
    cycles = 0;
    while (busy_o === 1'b1 && cycles < 40) begin
      cycles++;
      step();
    end
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 32'h0000_0000, 32'h8000_0000};
    vecs[4]  = '{MD_DIVU,  32'd100,       32'd7,        1'b1, 10, 32'h0000_0002, 32'h0000_000E};
    vecs[5]  = '{MD_MULT,  32'd7,         32'hFFFF_FFFE, 1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFF2};
    vecs[6]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 1'b1, 10, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7]  = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1, 5,  32'h0000_0001, 32'h0000_0000};
    vecs[8]  = '{MD_MTHI,  32'h0000_0011, 32'd9,        1'b0, 0,  32'h0000_0011, 32'h0000_0000};
    vecs[9]  = '{MD_MTLO,  32'h0000_0022, 32'd9,        1'b0, 0,  32'h0000_0011, 32'h0000_0022};
    vecs[10] = '{MD_DIVU,  32'd5,         32'd0,        1'b1, 10, 32'h0000_0011, 32'h0000_0022};
    vecs[11] = '{MD_DIV,   32'd9,         32'd0,        1'b1, 10, 32'h0000_0011, 32'h0000_0022};

    reset = 1'b1; op = MD_NONE; rs = 32'd0; rt = 32'd0;
    step(); step();
    reset = 1'b0;
    chk("reset_hi", hi_o, 32'd0);
    chk("reset_lo", lo_o, 32'd0);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    op = MD_MFHI;
    #1 chk("reset_mfhi", md_out_o, 32'd0);

    for (int i = 0; i < 12; i++) begin
      op = vecs[i].op; rs = vecs[i].rs; rt = vecs[i].rt;
      #1 chk($sformatf("v%0d_start", i), {31'd0, start_o}, {31'd0, vecs[i].exp_start});
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cycles);
      chk($sformatf("v%0d_hi", i), hi_o, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo_o, vecs[i].exp_lo);
      op = MD_MFHI;
      #1 chk($sformatf("v%0d_mfhi", i), md_out_o, vecs[i].exp_hi);
      op = MD_MFLO;
      #1 chk($sformatf("v%0d_mflo", i), md_out_o, vecs[i].exp_lo);
      op = MD_NONE;
      #1 chk($sformatf("v%0d_mdout_none", i), md_out_o, 32'd0);
    end

    // Ops arriving while busy must be dropped without restarting the count.
    op = MD_MULT; rs = 32'd2; rt = 32'd3;
    step();
    cyc = 0;
    while (busy_o === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 2) begin op = MD_MULT; rs = 32'd100; rt = 32'd100; end
      else if (cyc == 3) begin op = MD_MTLO; rs = 32'h55; rt = 32'd0; end
      else begin op = MD_NONE; rs = 32'd0; rt = 32'd0; end
      #1 chk($sformatf("busy_start_c%0d", cyc), {31'd0, start_o}, 32'd0);
      step();
    end
    op = MD_NONE;
    chk("busy_ignore_cycles", cyc, 5);
    chk("busy_ignore_hi", hi_o, 32'd0);
    chk("busy_ignore_lo", lo_o, 32'd6);
    op = MD_MULT;
    #1 chk("after_busy_start", {31'd0, start_o}, 32'd1);
    op = MD_NONE;

    // Reset in the fourth busy cycle of a divide discards the pending result.
    op = MD_DIV; rs = 32'd100; rt = 32'd3;
    step();
    op = MD_NONE; rs = 32'd0; rt = 32'd0;
    step(); step(); step();
    chk("pre_reset_busy", {31'd0, busy_o}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_hi", hi_o, 32'd0);
    chk("midrst_lo", lo_o, 32'd0);
    for (int k = 0; k < 12; k++) step();
    chk("midrst_late_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_late_hi", hi_o, 32'd0);
    chk("midrst_late_lo", lo_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
